// File: rtl/mcu51_bus_pkg.sv
// Shared types and constants for the 8051 external bus sequencer.
// Request encodings, default cycle lengths and the bus state enum.
package mcu51_bus_pkg;

    localparam logic [1:0] REQ_FETCH = 2'b00;
    localparam logic [1:0] REQ_READ  = 2'b01;
    localparam logic [1:0] REQ_WRITE = 2'b10;
    localparam logic [1:0] REQ_RSVD  = 2'b11;

    localparam int DEF_FETCH_LEN = 6;
    localparam int DEF_DATA_LEN  = 12;
    localparam int DEF_ALE_LEN   = 2;
    localparam int CNT_W         = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DREAD,
        ST_DWRITE
    } bus_state_e;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  wdata;
    } bus_req_t;

    function automatic bus_state_e req_state(input logic [1:0] ty);
        bus_state_e s;
        unique case (ty)
            REQ_FETCH: s = ST_FETCH;
            REQ_READ:  s = ST_DREAD;
            REQ_WRITE: s = ST_DWRITE;
            default:   s = ST_IDLE;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/ext_bus_ctrl_tick_cnt.sv
// Loadable tick counter for one bus cycle.
// last flags the final tick (t == len-1); load restarts at zero.
module bus_tick_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] len,
    output logic [W-1:0] t,
    output logic         last
);

    // Restart on load, otherwise advance while a cycle runs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t <= '0;
        end else if (load) begin
            t <= '0;
        end else if (en) begin
            t <= t + 1'b1;
        end
    end

    assign last = (t == len - W'(1));

endmodule

// File: rtl/ext_bus_ctrl.sv
// 8051 external bus cycle sequencer: fetch, MOVX read, MOVX write.
// Pin strobes decode from the registered state and tick count.
module ext_bus_ctrl
    import mcu51_bus_pkg::*;
#(
    parameter int FETCH_LEN = DEF_FETCH_LEN,
    parameter int DATA_LEN  = DEF_DATA_LEN,
    parameter int ALE_LEN   = DEF_ALE_LEN
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_type,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        resp_valid,
    output logic [7:0]  resp_data,
    output logic        busy,
    input  logic [7:0]  p0_in,
    output logic [7:0]  p0_out,
    output logic        p0_oe,
    output logic [7:0]  p2_out,
    output logic        ale,
    output logic        psen_n,
    output logic        rd_n,
    output logic        wr_n
);

    localparam logic [CNT_W-1:0] FLEN  = CNT_W'(FETCH_LEN);
    localparam logic [CNT_W-1:0] DLEN  = CNT_W'(DATA_LEN);
    localparam logic [CNT_W-1:0] ALEN  = CNT_W'(ALE_LEN);
    localparam logic [CNT_W-1:0] DLAST = CNT_W'(DATA_LEN - 1);
    localparam logic [CNT_W-1:0] DSAMP = CNT_W'(DATA_LEN - 2);

    bus_state_e       state_q;
    bus_state_e       state_d;
    bus_req_t         req_q;
    logic [CNT_W-1:0] t;
    logic [CNT_W-1:0] len;
    logic             cnt_last;
    logic             last;
    logic             accept;
    logic             start;
    logic             sample;

    assign len       = (state_q == ST_FETCH) ? FLEN : DLEN;
    assign busy      = (state_q != ST_IDLE);
    assign last      = busy & cnt_last;
    assign req_ready = ~busy | last;
    assign accept    = req_valid & req_ready;
    // Reserved requests are consumed without starting a cycle.
    assign start     = accept & (req_type != REQ_RSVD);

    assign sample = ((state_q == ST_FETCH) & cnt_last) |
                    ((state_q == ST_DREAD) & (t == DSAMP));

    bus_tick_cnt #(
        .W(CNT_W)
    ) u_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .load (start),
        .en   (busy),
        .len  (len),
        .t    (t),
        .last (cnt_last)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Latch the request; the address also holds P2 between cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q <= '0;
        end else if (start) begin
            req_q.addr  <= req_addr;
            req_q.wdata <= req_wdata;
        end
    end

    // Capture P0 and pulse resp_valid for one clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid <= 1'b0;
            resp_data  <= '0;
        end else begin
            resp_valid <= sample;
            if (sample) begin
                resp_data <= p0_in;
            end
        end
    end

    // Next state and pin decode for the current tick.
    always_comb begin
        state_d = state_q;
        ale     = 1'b0;
        psen_n  = 1'b1;
        rd_n    = 1'b1;
        wr_n    = 1'b1;
        p0_oe   = 1'b0;
        p0_out  = req_q.addr[7:0];
        p2_out  = req_q.addr[15:8];

        if (start) begin
            state_d = req_state(req_type);
        end else if (last) begin
            state_d = ST_IDLE;
        end

        unique case (1'b1)
            !busy: begin
            end
            busy && (t < ALEN): begin
                ale   = 1'b1;
                p0_oe = 1'b1;
            end
            busy && (t == ALEN): begin
                p0_oe = 1'b1;
            end
            busy && (t > ALEN): begin
                unique case (state_q)
                    ST_FETCH: psen_n = 1'b0;
                    ST_DREAD: rd_n   = (t == DLAST);
                    ST_DWRITE: begin
                        p0_oe  = 1'b1;
                        p0_out = req_q.wdata;
                        wr_n   = (t == DLAST);
                    end
                    default: begin
                    end
                endcase
            end
        endcase
    end

endmodule

// File: tb/tb_ext_bus_ctrl.sv
// Randomized bench for ext_bus_ctrl against a per-clock timeline model.
// Accepted requests paint expected pin values into future clock slots.
module tb_ext_bus_ctrl;

    localparam int F = 6;
    localparam int D = 12;
    localparam int A = 2;
    localparam int N = 8192;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_type;
    logic [15:0] req_addr;
    logic [7:0]  req_wdata;
    logic        resp_valid;
    logic [7:0]  resp_data;
    logic        busy;
    logic [7:0]  p0_in;
    logic [7:0]  p0_out;
    logic        p0_oe;
    logic [7:0]  p2_out;
    logic        ale;
    logic        psen_n;
    logic        rd_n;
    logic        wr_n;

    always #5 clk = ~clk;

    ext_bus_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_type  (req_type),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .resp_valid(resp_valid),
        .resp_data (resp_data),
        .busy      (busy),
        .p0_in     (p0_in),
        .p0_out    (p0_out),
        .p0_oe     (p0_oe),
        .p2_out    (p2_out),
        .ale       (ale),
        .psen_n    (psen_n),
        .rd_n      (rd_n),
        .wr_n      (wr_n)
    );

    typedef struct {
        logic [1:0]  ty;
        logic [15:0] addr;
        logic [7:0]  wd;
    } req_t;

    req_t q[$];

    bit          exp_on[N];
    bit          exp_ale[N];
    bit          exp_psen[N];
    bit          exp_rd[N];
    bit          exp_wr[N];
    bit          exp_oe[N];
    bit          exp_last[N];
    bit          exp_rv[N];
    int          exp_src[N];
    logic [7:0]  exp_p0[N];
    logic [7:0]  exp_p2[N];
    logic [7:0]  p0_hist[N];

    int          k;
    int          checks;
    int          errors;
    int          gap;
    int          gap_max;
    int          t0_at;
    bit          acc_pend;
    bit          fix_p0;
    logic [7:0]  fix_val;
    logic [7:0]  last_hi;
    logic [7:0]  last_resp;

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s clock %0d: got %h expected %h",
                     tag, k, got, exp);
        end
    endtask

    task automatic push(input logic [1:0] ty, input logic [15:0] addr,
                        input logic [7:0] wd);
        req_t r;
        r.ty   = ty;
        r.addr = addr;
        r.wd   = wd;
        q.push_back(r);
    endtask

    task automatic model_accept();
        req_t r;
        int   len;
        int   m;
        r = q.pop_front();
        if (r.ty == 2'b11) return;
        len   = (r.ty == 2'b00) ? F : D;
        t0_at = k + 1;
        for (int j = 0; j < len; j++) begin
            m = k + 1 + j;
            exp_on[m]   = 1'b1;
            exp_ale[m]  = (j < A);
            exp_oe[m]   = (j <= A) || (r.ty == 2'b10);
            exp_p0[m]   = (j <= A) ? r.addr[7:0] : r.wd;
            exp_p2[m]   = r.addr[15:8];
            exp_psen[m] = !(r.ty == 2'b00 && j > A);
            exp_rd[m]   = !(r.ty == 2'b01 && j > A && j <= len - 2);
            exp_wr[m]   = !(r.ty == 2'b10 && j > A && j <= len - 2);
            exp_last[m] = (j == len - 1);
        end
        if (r.ty == 2'b00) begin
            exp_rv[k + len + 1]  = 1'b1;
            exp_src[k + len + 1] = k + len;
        end else if (r.ty == 2'b01) begin
            exp_rv[k + len]  = 1'b1;
            exp_src[k + len] = k + len - 1;
        end
    endtask

    task automatic compare();
        bit on;
        on = exp_on[k];
        chk("busy", 16'(busy), 16'(on));
        chk("req_ready", 16'(req_ready), 16'(on ? exp_last[k] : 1'b1));
        chk("ale", 16'(ale), 16'(on ? exp_ale[k] : 1'b0));
        chk("psen_n", 16'(psen_n), 16'(on ? exp_psen[k] : 1'b1));
        chk("rd_n", 16'(rd_n), 16'(on ? exp_rd[k] : 1'b1));
        chk("wr_n", 16'(wr_n), 16'(on ? exp_wr[k] : 1'b1));
        chk("p0_oe", 16'(p0_oe), 16'(on ? exp_oe[k] : 1'b0));
        if (on) last_hi = exp_p2[k];
        chk("p2_out", 16'(p2_out), 16'(last_hi));
        if (on && exp_oe[k]) chk("p0_out", 16'(p0_out), 16'(exp_p0[k]));
        if (exp_rv[k]) last_resp = p0_hist[exp_src[k]];
        chk("resp_valid", 16'(resp_valid), 16'(exp_rv[k]));
        chk("resp_data", 16'(resp_data), 16'(last_resp));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        k++;
        if (acc_pend) begin
            req_valid = 1'b0;
            acc_pend  = 1'b0;
            gap = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
        end
        if (!req_valid) begin
            req_type  = 2'($urandom);
            req_addr  = 16'($urandom);
            req_wdata = 8'($urandom);
            if (q.size() > 0) begin
                if (gap > 0) begin
                    gap--;
                end else begin
                    req_valid = 1'b1;
                    req_type  = q[0].ty;
                    req_addr  = q[0].addr;
                    req_wdata = q[0].wd;
                end
            end
        end
        p0_in = fix_p0 ? fix_val : 8'($urandom);
        p0_hist[k] = p0_in;
        @(negedge clk);
        compare();
        if (req_valid && (exp_on[k] ? exp_last[k] : 1'b1)) begin
            model_accept();
            acc_pend = 1'b1;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() > 0 || req_valid) && n < 400) begin
            step();
            n++;
        end
        if (n >= 400) chk("drain_timeout", 16'(1), 16'(0));
        for (int i = 0; i < 16; i++) step();
    endtask

    task automatic reset_outputs(input string tag);
        chk({tag, "_ale"}, 16'(ale), 16'(0));
        chk({tag, "_psen_n"}, 16'(psen_n), 16'(1));
        chk({tag, "_rd_n"}, 16'(rd_n), 16'(1));
        chk({tag, "_wr_n"}, 16'(wr_n), 16'(1));
        chk({tag, "_p0_oe"}, 16'(p0_oe), 16'(0));
        chk({tag, "_p0_out"}, 16'(p0_out), 16'(0));
        chk({tag, "_p2_out"}, 16'(p2_out), 16'(0));
        chk({tag, "_resp_valid"}, 16'(resp_valid), 16'(0));
        chk({tag, "_resp_data"}, 16'(resp_data), 16'(0));
        chk({tag, "_busy"}, 16'(busy), 16'(0));
    endtask

    task automatic mid_reset();
        #2;
        rst_n = 1'b0;
        #1;
        reset_outputs("midrst");
        @(posedge clk);
        @(posedge clk);
        k += 2;
        #2;
        rst_n = 1'b1;
        for (int m = k - 2; m < k + 40; m++) begin
            exp_on[m] = 1'b0;
            exp_rv[m] = 1'b0;
        end
        last_hi   = 8'h00;
        last_resp = 8'h00;
    endtask

    initial begin
        int n;
        int r;
        checks    = 0;
        errors    = 0;
        k         = 0;
        gap       = 0;
        gap_max   = 0;
        acc_pend  = 1'b0;
        fix_p0    = 1'b0;
        fix_val   = 8'h00;
        last_hi   = 8'h00;
        last_resp = 8'h00;
        t0_at     = -100;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_type  = 2'b00;
        req_addr  = 16'h0000;
        req_wdata = 8'h00;
        p0_in     = 8'h00;

        #12;
        reset_outputs("reset");
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        chk("reset_ready", 16'(req_ready), 16'(1));

        fix_p0 = 1'b1;
        fix_val = 8'h75;
        push(2'b00, 16'h1234, 8'h00);
        drain();
        fix_val = 8'hC3;
        push(2'b01, 16'h00AB, 8'h00);
        drain();
        push(2'b10, 16'h8000, 8'h5A);
        drain();

        fix_p0 = 1'b0;
        push(2'b00, 16'h0100, 8'h00);
        push(2'b01, 16'h0042, 8'h00);
        drain();

        t0_at = -100;
        push(2'b10, 16'h1111, 8'hEE);
        n = 0;
        while (!(t0_at > 0 && k == t0_at + 5) && n < 40) begin
            step();
            n++;
        end
        chk("reach_write_t5", 16'(n < 40), 16'(1));
        chk("write_t5_wr_n", 16'(wr_n), 16'(0));
        mid_reset();
        chk("post_reset_ready", 16'(req_ready), 16'(1));
        push(2'b00, 16'h2222, 8'h00);
        drain();

        push(2'b11, 16'hFFFF, 8'h99);
        push(2'b00, 16'h3333, 8'h00);
        drain();

        gap_max = 3;
        for (int i = 0; i < 3000; i++) begin
            if (q.size() < 2) begin
                r = int'($urandom_range(7, 0));
                push((r < 3) ? 2'b00 : (r < 5) ? 2'b01 :
                     (r < 7) ? 2'b10 : 2'b11,
                     16'($urandom), 8'($urandom));
            end
            step();
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
